// File: rtl/alu_pkg.sv
// Shared opcode constants, controller state encoding and opcode classification helpers
// used by the issue controller and the ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LD     = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_NOT    = 4'd7;
  localparam logic [3:0] OP_CMP_EQ = 4'd8;
  localparam logic [3:0] OP_CMP_GT = 4'd9;
  localparam logic [3:0] OP_CMP_LT = 4'd10;
  localparam logic [3:0] OP_ST     = 4'd11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } state_e;

  function automatic logic is_alu_op(logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP_LT);
  endfunction

  function automatic logic is_cmp_op(logic [3:0] op);
    return (op >= OP_CMP_EQ) && (op <= OP_CMP_LT);
  endfunction

  function automatic logic is_ov_op(logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_illegal_op(logic [3:0] op);
    return op > OP_ST;
  endfunction

endpackage

// File: rtl/alu_resp_reg.sv
// Response holding register with valid/ready handshake and the retired-instruction counter.
module alu_resp_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [7:0]  data_i,
  input  logic        cmp_i,
  input  logic        ov_i,
  input  logic        err_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        cmp_o,
  output logic        ov_o,
  output logic        err_o,
  output logic [15:0] count_o
);

  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        cmp_q, cmp_d;
  logic        ov_q, ov_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cmp_d   = cmp_q;
    ov_d    = ov_q;
    err_d   = err_q;
    count_d = count_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      cmp_d   = cmp_i;
      ov_d    = ov_i;
      err_d   = err_i;
    end else if (valid_q && ready_i) begin
      // Fields stay put after retire; only valid drops.
      valid_d = 1'b0;
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      cmp_q   <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cmp_q   <= cmp_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cmp_o   = cmp_q;
  assign ov_o    = ov_q;
  assign err_o   = err_q;
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Accumulator-style issue controller: accepts one instruction, sequences the ALU through
// ISSUE/CAPTURE, updates the accumulator and holds the response until it is consumed.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        CLK,
  input  logic        CPU_Reset,
  input  logic        INS_Valid,
  output logic        INS_Ready,
  input  logic [3:0]  INS_OPCode,
  input  logic [7:0]  INS_Operand,
  output logic [3:0]  ALU_OPCode,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic        COMPARATORREG_EN,
  output logic        OV_EN,
  input  logic [7:0]  ALU_Resoult,
  input  logic        ALU_ComparatorResoult,
  input  logic        ALU_OV,
  output logic        RES_Valid,
  input  logic        RES_Ready,
  output logic [7:0]  RES_Data,
  output logic        RES_Cmp,
  output logic        RES_OV,
  output logic        RES_Err,
  output logic [15:0] INS_Count
);

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] op_q, op_d;
  logic [7:0] opnd_q, opnd_d;

  logic       resp_load;
  logic [7:0] resp_data;
  logic       resp_cmp;
  logic       resp_ov;
  logic       resp_err;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    resp_load = 1'b0;
    resp_data = 8'h00;
    resp_cmp  = 1'b0;
    resp_ov   = 1'b0;
    resp_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (INS_Valid) begin
          op_d   = INS_OPCode;
          opnd_d = INS_Operand;
          if (is_alu_op(INS_OPCode)) begin
            state_d = StIssue;
          end else begin
            // Direct path: response is ready one edge after accept.
            state_d   = StResp;
            resp_load = 1'b1;
            resp_err  = is_illegal_op(INS_OPCode);
            resp_data = acc_q;
            if (INS_OPCode == OP_LD) begin
              resp_data = INS_Operand;
              acc_d     = INS_Operand;
            end
          end
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        state_d   = StResp;
        resp_load = 1'b1;
        resp_cmp  = is_cmp_op(op_q) && ALU_ComparatorResoult;
        resp_ov   = is_ov_op(op_q) && ALU_OV;
        if (is_cmp_op(op_q)) begin
          resp_data = acc_q;
        end else begin
          resp_data = ALU_Resoult;
          acc_d     = ALU_Resoult;
        end
      end
      StResp: begin
        if (RES_Valid && RES_Ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      state_q <= StIdle;
      acc_q   <= 8'h00;
      op_q    <= OP_NOP;
      opnd_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 under reset.
  assign INS_Ready        = (state_q == StIdle) && !CPU_Reset;
  assign ALU_OPCode       = (state_q == StIssue) ? op_q : OP_NOP;
  assign COMPARATORREG_EN = (state_q == StIssue) && is_cmp_op(op_q);
  assign OV_EN            = (state_q == StIssue) && is_ov_op(op_q);
  assign ALU_A            = acc_q;
  assign ALU_B            = opnd_q;

  alu_resp_reg u_resp (
    .clk_i   (CLK),
    .rst_i   (CPU_Reset),
    .load_i  (resp_load),
    .data_i  (resp_data),
    .cmp_i   (resp_cmp),
    .ov_i    (resp_ov),
    .err_i   (resp_err),
    .ready_i (RES_Ready),
    .valid_o (RES_Valid),
    .data_o  (RES_Data),
    .cmp_o   (RES_Cmp),
    .ov_o    (RES_OV),
    .err_o   (RES_Err),
    .count_o (INS_Count)
  );

endmodule
